// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Desc     : Instruction fetch stage. Accepts a fetch address on a one-cycle
//            start pulse, performs a req/ack read of instruction memory and
//            presents the word plus its PC to decode over valid/ready.
//            Misaligned, out-of-range and unanswered fetches raise a sticky
//            fault that only rstn clears.
//            Optional macro IFETCH_ILLEGAL_CHECK_EN: fault (cause 100) on a
//            returned word whose low two bits are not 2'b11.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] IMEM_BASE = 32'h01000000,
    parameter logic [31:0] IMEM_LAST = 32'h010007FC,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fetch_start,
    input  logic [31:0] pc_addr,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        busy,
    output logic        fault,
    output logic [2:0]  fault_cause
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] c_NOP           = 32'h00000013;
    localparam logic [3:0]  c_COUNT_LAST    = 4'(TIMEOUT - 1);
    localparam logic [2:0]  c_CAUSE_ALIGN   = 3'b001;
    localparam logic [2:0]  c_CAUSE_RANGE   = 3'b010;
    localparam logic [2:0]  c_CAUSE_TIMEOUT = 3'b011;
`ifdef IFETCH_ILLEGAL_CHECK_EN
    localparam logic [2:0]  c_CAUSE_ILLEGAL = 3'b100;
`endif

    state_t      r_state,       w_state;
    logic        r_mem_req,     w_mem_req;
    logic [31:0] r_mem_addr,    w_mem_addr;
    logic [31:0] r_instr,       w_instr;
    logic [31:0] r_instr_pc,    w_instr_pc;
    logic        r_instr_valid, w_instr_valid;
    logic        r_fault,       w_fault;
    logic [2:0]  r_fault_cause, w_fault_cause;
    logic [3:0]  r_count,       w_count;
    logic        r_drop,        w_drop;
    logic        r_busy,        w_busy;

    // A flush arriving on the ack cycle itself also discards that word.
    logic        w_drop_now;
    assign w_drop_now = r_drop | flush;

    // State and datapath registers; rstn abandons any in-flight request at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= IMEM_BASE;
            r_instr       <= c_NOP;
            r_instr_pc    <= 32'h0;
            r_instr_valid <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= 3'b000;
            r_count       <= 4'd0;
            r_drop        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_mem_req     <= w_mem_req;
            r_mem_addr    <= w_mem_addr;
            r_instr       <= w_instr;
            r_instr_pc    <= w_instr_pc;
            r_instr_valid <= w_instr_valid;
            r_fault       <= w_fault;
            r_fault_cause <= w_fault_cause;
            r_count       <= w_count;
            r_drop        <= w_drop;
            r_busy        <= w_busy;
        end
    end

    // Next-state and next-output decode; every value holds unless changed below.
    always_comb begin
        w_state       = r_state;
        w_mem_req     = r_mem_req;
        w_mem_addr    = r_mem_addr;
        w_instr       = r_instr;
        w_instr_pc    = r_instr_pc;
        w_instr_valid = r_instr_valid;
        w_fault       = r_fault;
        w_fault_cause = r_fault_cause;
        w_count       = r_count;
        w_drop        = r_drop;

        case (r_state)
            S_IDLE: begin
                if (fetch_start && !flush) begin
                    if (pc_addr[1:0] != 2'b00) begin
                        w_fault       = 1'b1;
                        w_fault_cause = c_CAUSE_ALIGN;
                        w_state       = S_FAULT;
                    end else if ((pc_addr < IMEM_BASE) || (pc_addr > IMEM_LAST)) begin
                        w_fault       = 1'b1;
                        w_fault_cause = c_CAUSE_RANGE;
                        w_state       = S_FAULT;
                    end else begin
                        w_mem_addr = pc_addr;
                        w_mem_req  = 1'b1;
                        w_count    = 4'd0;
                        w_drop     = 1'b0;
                        w_state    = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (mem_ack) begin
                    w_instr    = mem_rdata;
                    w_instr_pc = r_mem_addr;
                    w_mem_req  = 1'b0;
                    w_drop     = 1'b0;
                    if (w_drop_now) begin
                        w_state = S_IDLE;
                    end else begin
`ifdef IFETCH_ILLEGAL_CHECK_EN
                        if (mem_rdata[1:0] != 2'b11) begin
                            w_fault       = 1'b1;
                            w_fault_cause = c_CAUSE_ILLEGAL;
                            w_state       = S_FAULT;
                        end else begin
                            w_instr_valid = 1'b1;
                            w_state       = S_HOLD;
                        end
`else
                        w_instr_valid = 1'b1;
                        w_state       = S_HOLD;
`endif
                    end
                end else if (r_count == c_COUNT_LAST) begin
                    w_mem_req     = 1'b0;
                    w_fault       = 1'b1;
                    w_fault_cause = c_CAUSE_TIMEOUT;
                    w_state       = S_FAULT;
                end else begin
                    w_count = r_count + 4'd1;
                    w_drop  = w_drop_now;
                end
            end

            S_HOLD: begin
                if (flush || instr_ready) begin
                    w_instr_valid = 1'b0;
                    w_state       = S_IDLE;
                end
            end

            S_FAULT: begin
                w_mem_req     = 1'b0;
                w_instr_valid = 1'b0;
                w_fault       = 1'b1;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state == S_REQ) || (w_state == S_HOLD);
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign fault       = r_fault;
    assign fault_cause = r_fault_cause;
    assign busy        = r_busy;

endmodule
`default_nettype wire
